audio_out: RTL and testbench

- I2S-style DAC serializer; the downstream mirror of the ADC deserializer. Sits at the end of the pedal chain, after the distortion/processing stages.
- Accepts stereo sample pairs from processing over a valid/ready handshake and holds one pair in a pending buffer.
- Shifts words out MSB-first on DACDAT, aligned to the codec-driven LRCLK.
- Detects and counts underruns when processing fails to supply a pair in time.

---
 rtl/audio_out.sv | 136 +++++++++++++
 tb/tb_audio_out.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/audio_out.sv
// I2S-style DAC serializer: one pending stereo pair, MSB-first output aligned to codec LRCLK.
// Optional build macro AUDIO_OUT_MUTE_ON_UNDERRUN_EN: send silence instead of repeating the last pair on underrun.
module audio_out #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  BCLK,
    input  logic                  RESET_N,
    input  logic                  LRCLK,
    input  logic [DATA_WIDTH-1:0] left_in,
    input  logic [DATA_WIDTH-1:0] right_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  DACDAT,
    output logic                  underrun,
    output logic [CNT_WIDTH-1:0]  underrun_count
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_e;

    state_e                  state_q, state_d;
    logic                    lrclk_prev_q;
    logic                    pend_full_q, pend_full_d;
    logic [DATA_WIDTH-1:0]   pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic [DATA_WIDTH-1:0]   act_l_q, act_l_d, act_r_q, act_r_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [BW-1:0]           bitcnt_q, bitcnt_d;
    logic                    dacdat_q, dacdat_d;
    logic                    underrun_q, underrun_d;
    logic [CNT_WIDTH-1:0]    ucnt_q, ucnt_d;

    logic                    lr_fall, lr_rise, frame_start, load;
    logic [DATA_WIDTH-1:0]   load_word;

    assign lr_fall = lrclk_prev_q & ~LRCLK;
    assign lr_rise = ~lrclk_prev_q & LRCLK;

    always_ff @(posedge BCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= SYNC;
            lrclk_prev_q <= 1'b0;
            pend_full_q  <= 1'b0;
            pend_l_q     <= '0;
            pend_r_q     <= '0;
            act_l_q      <= '0;
            act_r_q      <= '0;
            shift_q      <= '0;
            bitcnt_q     <= '0;
            dacdat_q     <= 1'b0;
            underrun_q   <= 1'b0;
            ucnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            lrclk_prev_q <= LRCLK;
            pend_full_q  <= pend_full_d;
            pend_l_q     <= pend_l_d;
            pend_r_q     <= pend_r_d;
            act_l_q      <= act_l_d;
            act_r_q      <= act_r_d;
            shift_q      <= shift_d;
            bitcnt_q     <= bitcnt_d;
            dacdat_q     <= dacdat_d;
            underrun_q   <= underrun_d;
            ucnt_q       <= ucnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_full_d = pend_full_q;
        pend_l_d    = pend_l_q;
        pend_r_d    = pend_r_q;
        act_l_d     = act_l_q;
        act_r_d     = act_r_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        dacdat_d    = 1'b0;
        underrun_d  = 1'b0;
        ucnt_d      = ucnt_q;
        frame_start = 1'b0;
        load        = 1'b0;
        load_word   = '0;

        case (state_q)
            SYNC:    if (lr_fall) begin frame_start = 1'b1; state_d = LEFT; end
            LEFT:    if (lr_rise) begin load = 1'b1; load_word = act_r_q; state_d = RIGHT; end
            RIGHT:   if (lr_fall) begin frame_start = 1'b1; state_d = LEFT; end
            default: state_d = SYNC;
        endcase

        if (frame_start) begin
            load = 1'b1;
            if (pend_full_q) begin
                act_l_d     = pend_l_q;
                act_r_d     = pend_r_q;
                pend_full_d = 1'b0;
                load_word   = pend_l_q;
            end else begin
                underrun_d = 1'b1;
                if (ucnt_q != '1) ucnt_d = ucnt_q + 1'b1;
`ifdef AUDIO_OUT_MUTE_ON_UNDERRUN_EN
                act_l_d   = '0;
                act_r_d   = '0;
                load_word = '0;
`else
                load_word = act_l_q;
`endif
            end
        end

        // Gated on the registered flag, so a pair accepted on an underrun frame start waits for the next frame.
        if (sample_valid && !pend_full_q) begin
            pend_full_d = 1'b1;
            pend_l_d    = left_in;
            pend_r_d    = right_in;
        end

        if (load) begin
            dacdat_d = load_word[DATA_WIDTH-1];
            shift_d  = {load_word[DATA_WIDTH-2:0], 1'b0};
            bitcnt_d = BW'(1);
        end else if (state_q != SYNC && bitcnt_q < BW'(DATA_WIDTH)) begin
            dacdat_d = shift_q[DATA_WIDTH-1];
            shift_d  = {shift_q[DATA_WIDTH-2:0], 1'b0};
            bitcnt_d = bitcnt_q + 1'b1;
        end
    end

    assign sample_ready   = ~pend_full_q;
    assign DACDAT         = dacdat_q;
    assign underrun       = underrun_q;
    assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_audio_out.sv
// Randomized bench for audio_out against a slot/queue-level reference model.
// A second instance with a 2-bit underrun counter exercises saturation.
module tb_audio_out;

    localparam int DW = 16;

    logic          BCLK = 1'b0;
    logic          RESET_N;
    logic          LRCLK;
    logic [DW-1:0] left_in, right_in;
    logic          sample_valid;
    logic          sample_ready, DACDAT, underrun;
    logic [7:0]    underrun_count;
    logic          sample_ready2, DACDAT2, underrun2;
    logic [1:0]    underrun_count2;

    audio_out #(.DATA_WIDTH(DW), .CNT_WIDTH(8)) dut (
        .BCLK(BCLK), .RESET_N(RESET_N), .LRCLK(LRCLK),
        .left_in(left_in), .right_in(right_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .DACDAT(DACDAT),
        .underrun(underrun), .underrun_count(underrun_count)
    );

    audio_out #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut2 (
        .BCLK(BCLK), .RESET_N(RESET_N), .LRCLK(LRCLK),
        .left_in(left_in), .right_in(right_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready2), .DACDAT(DACDAT2),
        .underrun(underrun2), .underrun_count(underrun_count2)
    );

    always #5 BCLK = ~BCLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: frame/slot view of the stream
    logic          m_prev, m_synced, m_left, m_und;
    logic [31:0]   pend[$];
    logic [DW-1:0] m_act_l, m_act_r, m_word;
    int            m_pos, m_ucnt;

    task automatic m_reset();
        m_prev = 1'b0; m_synced = 1'b0; m_left = 1'b0; m_und = 1'b0;
        pend.delete();
        m_act_l = '0; m_act_r = '0; m_word = '0;
        m_pos = 1000; m_ucnt = 0;
    endtask

    task automatic m_edge(input logic lr, input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r);
        logic fall, rise, acc;
        logic [31:0] pair;
        fall = m_prev && !lr;
        rise = !m_prev && lr;
        acc  = v && (pend.size() == 0);
        m_und = 1'b0;
        if (fall && !(m_synced && m_left)) begin
            m_synced = 1'b1; m_left = 1'b1;
            if (pend.size() != 0) begin
                pair = pend.pop_front();
                m_act_l = pair[31:16]; m_act_r = pair[15:0];
            end else begin
                m_und = 1'b1; m_ucnt++;
`ifdef AUDIO_OUT_MUTE_ON_UNDERRUN_EN
                m_act_l = '0; m_act_r = '0;
`endif
            end
            m_word = m_act_l; m_pos = 0;
        end else if (rise && m_synced && m_left) begin
            m_left = 1'b0; m_word = m_act_r; m_pos = 0;
        end else if (m_pos < 1000) begin
            m_pos++;
        end
        if (acc) pend.push_back({l, r});
        m_prev = lr;
    endtask

    task automatic check_outputs(input string sfx);
        logic exp_d;
        exp_d = (m_synced && m_pos < DW) ? m_word[DW-1-m_pos] : 1'b0;
        chk({"dacdat", sfx}, 32'(DACDAT), 32'(exp_d));
        chk({"ready", sfx}, 32'(sample_ready), 32'(pend.size() == 0));
        chk({"underrun", sfx}, 32'(underrun), 32'(m_und));
        chk({"ucount", sfx}, 32'(underrun_count), (m_ucnt > 255) ? 32'd255 : 32'(m_ucnt));
        chk({"underrun2", sfx}, 32'(underrun2), 32'(m_und));
        chk({"ucount2", sfx}, 32'(underrun_count2), (m_ucnt > 3) ? 32'd3 : 32'(m_ucnt));
    endtask

    // Drive one cycle's inputs just after a negedge, predict, then check at the next negedge.
    task automatic step(input logic lr, input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r);
        LRCLK = lr; sample_valid = v; left_in = l; right_in = r;
        if (RESET_N) m_edge(lr, v, l, r);
        @(negedge BCLK);
        check_outputs("");
    endtask

    task automatic run_frames(input int n, input int half_lo, input int half_hi, input int vmode);
        int half;
        logic v;
        for (int f = 0; f < n; f++) begin
            half = $urandom_range(half_hi, half_lo);
            for (int h = 0; h < 2; h++) begin
                for (int c = 0; c < half; c++) begin
                    v = (vmode == 1) ? 1'b1 : (vmode == 2) ? 1'($urandom_range(1, 0)) : 1'b0;
                    step(1'(h), v, DW'($urandom), DW'($urandom));
                end
            end
        end
    endtask

    initial begin
        RESET_N = 1'b0; LRCLK = 1'b1; sample_valid = 1'b0; left_in = '0; right_in = '0;
        m_reset();
        repeat (3) @(negedge BCLK);
        check_outputs("_rst");

        // Release with LRCLK high, pair queued before the first falling edge
        RESET_N = 1'b1;
        step(1'b1, 1'b1, 16'hA5C3, 16'h0F0F);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'($urandom), DW'($urandom));
        run_frames(3, 20, 20, 0);

        run_frames(8, 16, 16, 1);   // continuous streaming
        run_frames(6, 12, 12, 1);   // short slots
        run_frames(20, 8, 24, 2);   // random slot lengths and valid

        // Asynchronous reset in the middle of a left slot
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DW'($urandom), DW'($urandom));
        #2 RESET_N = 1'b0;
        #1 m_reset();
        check_outputs("_arst");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'($urandom), DW'($urandom));
        RESET_N = 1'b1;

        // One pair of 7FFF then starvation: one consumed frame followed by five underruns
        step(1'b0, 1'b1, 16'h7FFF, DW'($urandom));
        run_frames(7, 16, 16, 0);
        chk("ucount_final", 32'(underrun_count), 32'd5);
        chk("ucount2_final", 32'(underrun_count2), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
